// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_sram_ctrl_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;
   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOW  = 2'd1;
   localparam state_t ST_HIGH = 2'd2;
   localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mem_sram_ctrl.sv
// Turns a 32-bit MEM-stage load/store into two halfword SRAM phases,
// freezing the pipeline via ready until the access completes.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no access; a request is latched and the pipeline frozen
// LOW     | halfword at {index,0}: bits [15:0]
// HIGH    | halfword at {index,1}: bits [31:16]
// DONE    | one-cycle release; incoming requests belong to this access
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
   parameter int unsigned PHASE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        address,
   input  logic [31:0]        st_val,
   output logic [31:0]        rd_val,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] sram_dq,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam logic [3:0] CNT_LAST = 4'(PHASE_CYCLES - 1);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [16:0]        idx_q, idx_d;
   logic [31:0]        st_q, st_d;
   logic [31:0]        rd_q, rd_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;

   logic [31:0]        offset;
   logic               req;
   logic               in_phase;
   logic               last;
   logic               dq_oe;
   logic [SRAM_DW-1:0] dq_out;
   logic               unused_bits;

   // Out-of-range addresses simply wrap into the 2^17-word window.
   assign offset      = address - BASE_ADDR;
   assign unused_bits = ^{offset[31:19], offset[1:0]};

   assign req      = mem_r_en | mem_w_en;
   assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);
   assign last     = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      st_d    = st_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               wr_d    = mem_w_en;
               idx_d   = offset[18:2];
               st_d    = st_val;
               cnt_d   = 4'd0;
               addr_d  = {offset[18:2], 1'b0};
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (last) begin
               cnt_d   = 4'd0;
               addr_d  = {idx_q, 1'b1};
               state_d = ST_HIGH;
               if (!wr_q) rd_d[15:0] = sram_dq;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_HIGH: begin
            if (last) begin
               cnt_d   = 4'd0;
               state_d = ST_DONE;
               if (!wr_q) rd_d[31:16] = sram_dq;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         st_q    <= '0;
         rd_q    <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         st_q    <= st_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
      end
   end

   // Strobe rises on the last phase cycle so write data outlives it by one cycle.
   assign sram_we_n = !(in_phase && wr_q && !last);
   assign sram_oe_n = !(in_phase && !wr_q);
   assign dq_oe     = in_phase && wr_q;
   assign dq_out    = (state_q == ST_HIGH) ? st_q[31:16] : st_q[15:0];
   assign sram_dq   = dq_oe ? dq_out : {SRAM_DW{1'bz}};

   assign sram_addr = addr_q;
   assign rd_val    = rd_q;
   // rst term keeps ready high while reset is held even if a request is pending.
   assign ready     = (state_q == ST_DONE) ||
                      ((state_q == ST_IDLE) && !(req && rst));

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: vector table plus multi-cycle corner sequences.
module tb_mem_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_r_en, a_w_en, b_r_en, b_w_en;
   logic [31:0] address, st_val;
   logic [31:0] rd_a, rd_b;
   logic        ready_a, ready_b;
   wire  [15:0] dq_a, dq_b;
   logic [17:0] saddr_a, saddr_b;
   logic        we_a, oe_a, we_b, oe_b;
   logic [15:0] lo_w, hi_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // SRAM model: returns lo_w on even halfword addresses, hi_w on odd ones
   assign dq_a = !oe_a ? (saddr_a[0] ? hi_w : lo_w) : 16'hzzzz;
   assign dq_b = !oe_b ? (saddr_b[0] ? hi_w : lo_w) : 16'hzzzz;

   mem_sram_ctrl dut_a (
      .clk(clk), .rst(rst), .mem_r_en(a_r_en), .mem_w_en(a_w_en),
      .address(address), .st_val(st_val), .rd_val(rd_a), .ready(ready_a),
      .sram_dq(dq_a), .sram_addr(saddr_a), .sram_we_n(we_a), .sram_oe_n(oe_a)
   );

   mem_sram_ctrl #(.PHASE_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .mem_r_en(b_r_en), .mem_w_en(b_w_en),
      .address(address), .st_val(st_val), .rd_val(rd_b), .ready(ready_b),
      .sram_dq(dq_b), .sram_addr(saddr_b), .sram_we_n(we_b), .sram_oe_n(oe_b)
   );

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] st;
      logic [15:0] lo;
      logic [15:0] hi;
      logic [17:0] exp_addr;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One access on dut_a (PHASE_CYCLES=2); hold keeps the request up through DONE.
   task automatic access_a(input vec_t v, input bit hold);
      int          low_cnt, we_low, oe_low, p, k;
      bit          done, addr_ok, bus_ok, is_wr, in_hi;
      logic [17:0] ea;
      logic [15:0] ed;
      @(negedge clk);
      a_w_en = v.we; a_r_en = v.re; address = v.addr; st_val = v.st;
      lo_w = v.lo; hi_w = v.hi;
      is_wr = v.we;
      low_cnt = 0; we_low = 0; oe_low = 0;
      done = 0; addr_ok = 1; bus_ok = 1;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (!ready_a) begin
            low_cnt++;
            if (low_cnt >= 2) begin
               p     = low_cnt - 2;
               in_hi = (p >= 2);
               k     = p % 2;
               ea    = in_hi ? {v.exp_addr[17:1], 1'b1} : v.exp_addr;
               ed    = in_hi ? v.st[31:16] : v.st[15:0];
               if (saddr_a !== ea) addr_ok = 0;
               if (!we_a) we_low++;
               if (!oe_a) oe_low++;
               if (is_wr) begin
                  if (we_a !== (k == 1)) bus_ok = 0;
                  if (dq_a !== ed) bus_ok = 0;
               end else if (oe_a !== 1'b0 || dut_a.dq_oe !== 1'b0) begin
                  bus_ok = 0;
               end
            end
         end else if (low_cnt > 0) begin
            done = 1;
            check("done_strobes", {29'd0, we_a, oe_a, dut_a.dq_oe}, 32'd6);
            check("done_rd_val", rd_a, v.exp_rd);
            check("done_addr_hold", {14'd0, saddr_a}, {14'd0, v.exp_addr[17:1], 1'b1});
            if (!hold) begin
               a_w_en = 0; a_r_en = 0;
            end
         end
      end
      if (!done) check("access_timeout", 32'd0, 32'd1);
      check("freeze_len", low_cnt, 5);
      check("phase_addr", {31'd0, addr_ok}, 32'd1);
      check("phase_bus", {31'd0, bus_ok}, 32'd1);
      check("we_low_cycles", we_low, is_wr ? 2 : 0);
      check("oe_low_cycles", oe_low, is_wr ? 0 : 4);
   endtask

   initial begin
      bit          quiet;
      int          low_cnt;
      bit          addr_ok, done;
      vec_t        v;

      // we, re, addr, st, sram lo, sram hi, sram_addr of LOW, rd_val expected
      vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 16'h0000, 16'h0000, 18'd2,      32'h00000000};
      vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 16'hBEEF, 16'hDEAD, 18'd2,      32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 16'h5555, 16'h6666, 18'd0,      32'hDEADBEEF};
      vecs[3] = '{1'b0, 1'b1, 32'd1043, 32'h00000000, 16'h1111, 16'h2222, 18'd8,      32'h22221111};
      vecs[4] = '{1'b1, 1'b0, 32'd1000, 32'hA5A55A5A, 16'h7777, 16'h8888, 18'd262132, 32'h22221111};
      vecs[5] = '{1'b0, 1'b1, 32'd525308, 32'h00000000, 16'h0F0F, 16'hF0F0, 18'd262142, 32'hF0F00F0F};

      rst = 1'b0;
      a_r_en = 0; a_w_en = 0; b_r_en = 0; b_w_en = 0;
      address = 0; st_val = 0; lo_w = 0; hi_w = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", {31'd0, ready_a}, 32'd1);
      check("rst_we_oe", {30'd0, we_a, oe_a}, 32'd3);
      check("rst_rd_val", rd_a, 32'd0);
      check("rst_sram_addr", {14'd0, saddr_a}, 32'd0);
      check("rst_dq_oe", {31'd0, dut_a.dq_oe}, 32'd0);
      check("rst_b_rd_val", rd_b, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) access_a(vecs[i], 1'b0);

      // Request held through DONE must not launch a second access
      access_a(vecs[1], 1'b1);
      @(negedge clk);
      a_r_en = 0;
      #1;
      check("held_idle_ready", {31'd0, ready_a}, 32'd1);
      quiet = 1;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (!oe_a || !we_a || !ready_a) quiet = 0;
      end
      check("held_no_access", {31'd0, quiet}, 32'd1);
      access_a(vecs[2], 1'b0);

      // Reset during the HIGH phase of a write
      @(negedge clk);
      a_w_en = 1; address = 32'd1028; st_val = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      #1;
      check("pre_rst_high_we", {31'd0, we_a}, 32'd0);
      check("pre_rst_high_addr", {14'd0, saddr_a}, 32'd3);
      rst = 1'b0;
      #1;
      check("inrst_we", {31'd0, we_a}, 32'd1);
      check("inrst_dq_oe", {31'd0, dut_a.dq_oe}, 32'd0);
      check("inrst_ready", {31'd0, ready_a}, 32'd1);
      check("inrst_rd_val", rd_a, 32'd0);
      check("inrst_sram_addr", {14'd0, saddr_a}, 32'd0);
      @(negedge clk);
      a_w_en = 0;
      rst = 1'b1;
      quiet = 1;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (!oe_a || !we_a || !ready_a || dut_a.dq_oe) quiet = 0;
      end
      check("post_rst_idle", {31'd0, quiet}, 32'd1);

      // PHASE_CYCLES=4 read at the top word of the window
      @(negedge clk);
      b_r_en = 1; address = 32'd525308; lo_w = 16'h1357; hi_w = 16'h2468;
      low_cnt = 0; addr_ok = 1; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (!ready_b) begin
            low_cnt++;
            if (low_cnt >= 2 && low_cnt <= 5 && saddr_b !== 18'd262142) addr_ok = 0;
            if (low_cnt >= 6 && saddr_b !== 18'd262143) addr_ok = 0;
            if (low_cnt >= 2 && oe_b !== 1'b0) addr_ok = 0;
         end else if (low_cnt > 0) begin
            done = 1;
            b_r_en = 0;
            check("p4_rd_val", rd_b, 32'h24681357);
         end
      end
      if (!done) check("p4_timeout", 32'd0, 32'd1);
      check("p4_freeze_len", low_cnt, 9);
      check("p4_phase_addr", {31'd0, addr_ok}, 32'd1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, port rst.
REQ-002 Parameter BASE_ADDR, default 1024: byte address mapped to SRAM word 0.
REQ-003 Parameter PHASE_CYCLES, default 2, legal range 2..15: clock cycles per halfword SRAM phase.
REQ-004 clk  input  1  pipeline clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 mem_r_en  input  1  MEM-stage load request (level).
REQ-007 mem_w_en  input  1  MEM-stage store request (level).
REQ-008 address  input  32  byte address from EXE ALU result.
REQ-009 st_val  input  32  store data (Reg2 of the instruction).
REQ-010 rd_val  output  32  load result to WB.
REQ-011 ready  output  1  high = pipeline may advance; low = freeze all pipeline registers.
REQ-012 sram_dq  inout  16  SRAM data bus.
REQ-013 sram_addr  output  18  SRAM halfword address.
REQ-014 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-015 sram_oe_n  output  1  SRAM output enable, active-low.

Function
REQ-016 FSM states SHALL be IDLE, LOW, HIGH, DONE; a phase counter SHALL count 0..PHASE_CYCLES-1 in LOW and HIGH.
REQ-017 IDLE: if mem_w_en or mem_r_en, latch address, st_val and op (write if mem_w_en, else read), clear counter, go to LOW; otherwise stay.
REQ-018 mem_w_en and mem_r_en both high SHALL be treated as a write.
REQ-019 Word index = (address - BASE_ADDR) bits [18:2], truncated modulo 2^17; address[1:0] ignored; no range error is raised.
REQ-020 sram_addr SHALL be {index, 1'b0} in LOW and {index, 1'b1} in HIGH; it holds its last value in IDLE/DONE.
REQ-021 LOW/HIGH: on counter = PHASE_CYCLES-1 advance LOW->HIGH (counter cleared) or HIGH->DONE; otherwise increment.
REQ-022 Read phases: sram_oe_n=0, dq tristated; on the last phase cycle capture sram_dq into rd_val[15:0] (LOW) or rd_val[31:16] (HIGH).
REQ-023 Write phases: dq driven with latched st_val[15:0] (LOW) or st_val[31:16] (HIGH) for every phase cycle; sram_we_n=0 on all phase cycles except the last, so data holds one cycle after the strobe rises.
REQ-024 sram_oe_n=1 and sram_we_n=1 in IDLE, DONE and during any write; dq tristated in IDLE and DONE.
REQ-025 DONE SHALL last exactly one cycle and go to IDLE unconditionally; requests present in DONE are ignored (they belong to the instruction now completing).
REQ-026 ready (combinational) SHALL be 0 in LOW and HIGH, and in IDLE when a request is present; 1 in DONE and in idle IDLE.
REQ-027 Freeze length SHALL be 2*PHASE_CYCLES+1 cycles per access (5 at default); back-to-back accesses incur one idle-free IDLE entry cycle each.
REQ-028 rd_val SHALL hold its value except at read captures; writes never alter it.

Reset
REQ-029 rst low SHALL immediately force IDLE, counter 0, rd_val 0, sram_addr 0, sram_we_n 1, sram_oe_n 1, dq tristated, ready 1; an access in flight is abandoned.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef, the SRAM address/data widths (18, 16) and the BASE_ADDR default.
REQ-031 No sub-module is required; FSM, counter and datapath live in mem_sram_ctrl.

Verification
REQ-032 Store 0xDEADBEEF at address 1028 -> sram_addr 2 with dq 0xBEEF, then 3 with 0xDEAD; we_n low one cycle per phase; ready low 5 cycles.
REQ-033 Load at 1028 with SRAM model returning 0xBEEF/0xDEAD -> rd_val 0xDEADBEEF in DONE cycle, ready high that cycle only after 5 low.
REQ-034 Load and store both asserted at 1024 with st_val 0x12345678 -> write performed at sram_addr 0/1, rd_val unchanged.
REQ-035 Request held through DONE -> no second access; FSM in IDLE next cycle; new request then starts a fresh 5-cycle freeze.
REQ-036 rst asserted in HIGH of a write -> next sample: we_n 1, dq high-Z, ready 1, rd_val 0; after release, idle with no access.
REQ-037 PHASE_CYCLES=4, load at 1024+4*131071 -> sram_addr 262142/262143, ready low 9 cycles.
